// File: rtl/ppu_vram_port_ctrl.sv
// PPU VRAM port controller: arbitrates the single write port and the single
// sync-read port of the 16 KB VRAM between the CPU register path
// ($2000/$2002/$2006/$2007) and the renderer fetch engine.
//
// Handshake: the renderer holds rend_req (with rend_addr stable) until it sees
// rend_grant high in the same cycle; its data follows one cycle later with
// rend_valid high for exactly one cycle. CPU strobes (cpu_we/cpu_re) are single
// cycle and are accepted into a one-entry slot; cpu_busy reports a pending op.
module ppu_vram_port_ctrl #(
    parameter int ADDR_W   = 14,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [15:0]       cpu_address,
    input  logic [7:0]        cpu_data_in,
    input  logic              cpu_we,
    input  logic              cpu_re,
    output logic [7:0]        cpu_data_out,
    output logic              cpu_busy,
    output logic              overrun,
    input  logic              rend_req,
    input  logic [ADDR_W-1:0] rend_addr,
    output logic              rend_grant,
    output logic              rend_valid,
    output logic [7:0]        rend_data,
    output logic [ADDR_W-1:0] vram_w_addr,
    output logic [ADDR_W-1:0] vram_r_addr,
    output logic              vram_we,
    output logic [7:0]        vram_wdata,
    input  logic [7:0]        vram_rdata
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    // Tag of the read issued last cycle; steers the returning memory byte.
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_CPU  = 2'd1,
        TAG_REND = 2'd2
    } rd_tag_t;

    rd_tag_t           rd_tag;
    rd_tag_t           rd_tag_next;

    logic [ADDR_W-1:0] v;
    logic [5:0]        t_hi;
    logic              w_toggle;
    logic              inc32;

    logic              slot_full;
    logic              slot_write;
    logic [ADDR_W-1:0] slot_addr;
    logic [7:0]        slot_data;
    logic [CNT_W-1:0]  wait_cnt;

    // Register decode: exact match on $2000-$2007, low three bits select.
    logic              reg_hit;
    logic              wr_2000;
    logic              rd_2002;
    logic              wr_2006;
    logic              acc_2007;
    logic              slot_load;
    logic [ADDR_W-1:0] v_step;

    logic              starved;
    logic              issue_cpu;
    logic              grant;

    assign reg_hit   = (cpu_address[15:3] == 13'h0400);
    assign wr_2000   = cpu_we && reg_hit && (cpu_address[2:0] == 3'd0);
    assign rd_2002   = cpu_re && reg_hit && (cpu_address[2:0] == 3'd2);
    assign wr_2006   = cpu_we && reg_hit && (cpu_address[2:0] == 3'd6);
    assign acc_2007  = (cpu_we || cpu_re) && reg_hit && (cpu_address[2:0] == 3'd7);
    // A load only happens when the slot was empty at the start of the cycle,
    // so a load can never coincide with the issue of the same slot.
    assign slot_load = acc_2007 && !slot_full;
    assign v_step    = inc32 ? ADDR_W'(32) : ADDR_W'(1);

    // Priority: starved CPU op, then renderer, then any pending CPU op.
    assign starved   = slot_full && (wait_cnt == CNT_W'(MAX_WAIT));
    assign issue_cpu = slot_full && (starved || !rend_req);
    assign grant     = rend_req && !starved;

    assign rend_grant = grant;
    assign cpu_busy   = slot_full;
    assign rend_valid = (rd_tag == TAG_REND);
    assign rend_data  = (rd_tag == TAG_REND) ? vram_rdata : 8'h00;

    // Drive the VRAM ports for whichever requester issues this cycle.
    always_comb begin
        vram_we     = 1'b0;
        vram_w_addr = '0;
        vram_wdata  = 8'h00;
        vram_r_addr = '0;
        rd_tag_next = TAG_NONE;
        if (grant) begin
            vram_r_addr = rend_addr;
            rd_tag_next = TAG_REND;
        end else if (issue_cpu && slot_write) begin
            vram_we     = 1'b1;
            vram_w_addr = slot_addr;
            vram_wdata  = slot_data;
        end else if (issue_cpu) begin
            vram_r_addr = slot_addr;
            rd_tag_next = TAG_CPU;
        end
    end

    // Read-tag register: cleared every cycle unless a new read is issued.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_tag <= TAG_NONE;
        end else begin
            rd_tag <= rd_tag_next;
        end
    end

    // CPU-visible address state: increment mode, write toggle, t_hi and v.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v        <= '0;
            t_hi     <= 6'h00;
            w_toggle <= 1'b0;
            inc32    <= 1'b0;
        end else begin
            if (wr_2000) begin
                inc32 <= cpu_data_in[2];
            end
            if (rd_2002) begin
                w_toggle <= 1'b0;
            end
            if (wr_2006) begin
                if (!w_toggle) begin
                    t_hi     <= cpu_data_in[5:0];
                    w_toggle <= 1'b1;
                end else begin
                    v        <= ADDR_W'({t_hi, cpu_data_in});
                    w_toggle <= 1'b0;
                end
            end
            if (slot_load) begin
                v <= v + v_step;
            end
        end
    end

    // Pending-op slot, starvation counter and sticky overrun flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_full  <= 1'b0;
            slot_write <= 1'b0;
            slot_addr  <= '0;
            slot_data  <= 8'h00;
            wait_cnt   <= '0;
            overrun    <= 1'b0;
        end else begin
            if (slot_load) begin
                slot_full  <= 1'b1;
                slot_write <= cpu_we;
                slot_addr  <= v;
                slot_data  <= cpu_data_in;
            end else if (issue_cpu) begin
                slot_full <= 1'b0;
            end
            if (acc_2007 && slot_full) begin
                overrun <= 1'b1;
            end
            if (issue_cpu) begin
                wait_cnt <= '0;
            end else if (grant && slot_full) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

    // $2007 read buffer refills from the byte returned for a CPU read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_data_out <= 8'h00;
        end else if (rd_tag == TAG_CPU) begin
            cpu_data_out <= vram_rdata;
        end
    end

endmodule
